// File: rtl/hash_row_serializer.sv
// rtl/hash_row_serializer.sv - serializes a hashed batch into one output beat per valid row
// Holds one batch plus one registered beat so a new batch can enter while the last row leaves.
module hash_row_serializer #(
  parameter int HASH_ISSUE_WIDTH      = 32,
  parameter int HASH_ISSUE_WIDTH_LOG2 = 5,
  parameter int ROW_SIZE              = 8,
  parameter int ADDR_WIDTH            = 32,
  parameter int META_MATCH_LEN_WIDTH  = 4
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    input_valid,
  input  logic [ADDR_WIDTH-1:0]                                   input_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                             input_row_valid,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                    input_history_valid_vec,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0]         input_history_addr_vec,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*META_MATCH_LEN_WIDTH-1:0] input_meta_match_len_vec,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                    input_meta_match_can_ext_vec,
  input  logic [HASH_ISSUE_WIDTH*8-1:0]                           input_data,
  input  logic                                                    input_delim,
  output logic                                                    input_ready,
  output logic                                                    output_valid,
  output logic [ADDR_WIDTH-1:0]                                   output_addr,
  output logic [HASH_ISSUE_WIDTH_LOG2-1:0]                        output_offset,
  output logic [ROW_SIZE-1:0]                                     output_history_valid,
  output logic [ROW_SIZE*ADDR_WIDTH-1:0]                          output_history_addr,
  output logic [ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]                output_meta_match_len,
  output logic [ROW_SIZE-1:0]                                     output_meta_match_can_ext,
  output logic [HASH_ISSUE_WIDTH*8-1:0]                           output_data,
  output logic                                                    output_last,
  output logic                                                    output_delim,
  output logic                                                    output_empty,
  input  logic                                                    output_ready
);
  localparam int HW = HASH_ISSUE_WIDTH;
  localparam int LW = HASH_ISSUE_WIDTH_LOG2;
  localparam int RS = ROW_SIZE;
  localparam int AW = ADDR_WIDTH;
  localparam int ML = META_MATCH_LEN_WIDTH;

  logic                             buf_full_q, buf_full_d;
  logic [HW-1:0]                    rem_q, rem_d;
  logic                             empty_buf_q, delim_buf_q;
  logic [AW-1:0]                    head_q;
  logic [HW-1:0][RS-1:0]            hv_q;
  logic [HW-1:0][RS-1:0][AW-1:0]    ha_q;
  logic [HW-1:0][RS*ML-1:0]         ml_q;
  logic [HW-1:0][RS-1:0]            me_q;
  logic [HW*8-1:0]                  data_q;

  logic                             out_valid_q, out_last_q, out_delim_q, out_empty_q;
  logic [AW-1:0]                    out_addr_q;
  logic [LW-1:0]                    out_offset_q;
  logic [RS-1:0]                    out_hv_q, out_me_q;
  logic [RS*AW-1:0]                 out_ha_q;
  logic [RS*ML-1:0]                 out_ml_q;
  logic [HW*8-1:0]                  out_data_q;

  logic [LW-1:0]                    idx;
  logic [HW-1:0]                    rem_rest;
  logic [AW-1:0]                    row_addr;
  logic [RS-1:0]                    filt;
  logic                             load_out, last_load, accept, capture;

  always_comb begin
    idx = '0;
    for (int k = HW - 1; k >= 0; k--) begin
      if (rem_q[k]) idx = LW'(k);
    end
  end

  // rem with its lowest set bit cleared; zero means the row being loaded is the batch's last
  assign rem_rest    = rem_q & (rem_q - HW'(1));
  assign last_load   = empty_buf_q || ((rem_q != '0) && (rem_rest == '0));
  assign load_out    = buf_full_q && (!out_valid_q || output_ready);
  assign input_ready = !buf_full_q || (load_out && last_load);
  assign accept      = input_valid && input_ready;
  assign capture     = accept && ((input_row_valid != '0) || input_delim);
  assign row_addr    = head_q + AW'(idx);

  always_comb begin
    filt = '0;
    for (int j = 0; j < RS; j++) begin
      filt[j] = hv_q[idx][j] && (ha_q[idx][j] < row_addr);
    end
  end

  always_comb begin
    buf_full_d = buf_full_q;
    rem_d      = rem_q;
    if (capture) begin
      buf_full_d = 1'b1;
      rem_d      = input_row_valid;
    end else if (load_out) begin
      rem_d = rem_rest;
      if (last_load) buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q   <= 1'b0;
      rem_q        <= '0;
      empty_buf_q  <= 1'b0;
      delim_buf_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_delim_q  <= 1'b0;
      out_empty_q  <= 1'b0;
      out_addr_q   <= '0;
      out_offset_q <= '0;
      out_hv_q     <= '0;
      out_ha_q     <= '0;
      out_ml_q     <= '0;
      out_me_q     <= '0;
      out_data_q   <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      rem_q      <= rem_d;
      if (load_out) begin
        out_valid_q  <= 1'b1;
        out_addr_q   <= row_addr;
        out_offset_q <= idx;
        out_hv_q     <= empty_buf_q ? '0 : filt;
        out_ha_q     <= empty_buf_q ? '0 : ha_q[idx];
        out_ml_q     <= empty_buf_q ? '0 : ml_q[idx];
        out_me_q     <= empty_buf_q ? '0 : me_q[idx];
        out_data_q   <= data_q;
        out_last_q   <= last_load;
        out_delim_q  <= last_load && delim_buf_q;
        out_empty_q  <= empty_buf_q;
      end else if (output_ready) begin
        out_valid_q <= 1'b0;
      end
      if (capture) begin
        empty_buf_q <= (input_row_valid == '0);
        delim_buf_q <= input_delim;
        head_q      <= input_head_addr;
        hv_q        <= input_history_valid_vec;
        ha_q        <= input_history_addr_vec;
        ml_q        <= input_meta_match_len_vec;
        me_q        <= input_meta_match_can_ext_vec;
        data_q      <= input_data;
      end
    end
  end

  assign output_valid              = out_valid_q;
  assign output_addr               = out_addr_q;
  assign output_offset             = out_offset_q;
  assign output_history_valid      = out_hv_q;
  assign output_history_addr       = out_ha_q;
  assign output_meta_match_len     = out_ml_q;
  assign output_meta_match_can_ext = out_me_q;
  assign output_data               = out_data_q;
  assign output_last               = out_last_q;
  assign output_delim              = out_delim_q;
  assign output_empty              = out_empty_q;
endmodule

// File: tb/tb_hash_row_serializer.sv
// tb/tb_hash_row_serializer.sv - self-checking bench for hash_row_serializer
// Expected beats come from a per-batch row-list model of the serializer rules.
module tb_hash_row_serializer;
  localparam int HW = 4;
  localparam int LW = 2;
  localparam int RS = 2;
  localparam int AW = 16;
  localparam int ML = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    input_valid = 1'b0;
  logic [AW-1:0]           input_head_addr = '0;
  logic [HW-1:0]           input_row_valid = '0;
  logic [HW*RS-1:0]        input_history_valid_vec = '0;
  logic [HW*RS*AW-1:0]     input_history_addr_vec = '0;
  logic [HW*RS*ML-1:0]     input_meta_match_len_vec = '0;
  logic [HW*RS-1:0]        input_meta_match_can_ext_vec = '0;
  logic [HW*8-1:0]         input_data = '0;
  logic                    input_delim = 1'b0;
  logic                    input_ready;
  logic                    output_valid;
  logic [AW-1:0]           output_addr;
  logic [LW-1:0]           output_offset;
  logic [RS-1:0]           output_history_valid;
  logic [RS*AW-1:0]        output_history_addr;
  logic [RS*ML-1:0]        output_meta_match_len;
  logic [RS-1:0]           output_meta_match_can_ext;
  logic [HW*8-1:0]         output_data;
  logic                    output_last;
  logic                    output_delim;
  logic                    output_empty;
  logic                    output_ready = 1'b0;

  typedef struct packed {
    logic [AW-1:0]       head;
    logic [HW-1:0]       rv;
    logic [HW*RS-1:0]    hv;
    logic [HW*RS*AW-1:0] ha;
    logic [HW*RS*ML-1:0] ml;
    logic [HW*RS-1:0]    me;
    logic [HW*8-1:0]     data;
    logic                delim;
  } batch_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LW-1:0]    off;
    logic [RS-1:0]    hv;
    logic [RS*AW-1:0] ha;
    logic [RS*ML-1:0] ml;
    logic [RS-1:0]    me;
    logic [HW*8-1:0]  data;
    logic             last;
    logic             delim;
    logic             empty;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  obs_q[$];
  int     obs_cyc[$];
  batch_t stim_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  hash_row_serializer #(
    .HASH_ISSUE_WIDTH(HW), .HASH_ISSUE_WIDTH_LOG2(LW), .ROW_SIZE(RS),
    .ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .input_valid(input_valid), .input_head_addr(input_head_addr),
    .input_row_valid(input_row_valid), .input_history_valid_vec(input_history_valid_vec),
    .input_history_addr_vec(input_history_addr_vec),
    .input_meta_match_len_vec(input_meta_match_len_vec),
    .input_meta_match_can_ext_vec(input_meta_match_can_ext_vec),
    .input_data(input_data), .input_delim(input_delim), .input_ready(input_ready),
    .output_valid(output_valid), .output_addr(output_addr), .output_offset(output_offset),
    .output_history_valid(output_history_valid), .output_history_addr(output_history_addr),
    .output_meta_match_len(output_meta_match_len),
    .output_meta_match_can_ext(output_meta_match_can_ext),
    .output_data(output_data), .output_last(output_last), .output_delim(output_delim),
    .output_empty(output_empty), .output_ready(output_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t cur_beat();
    beat_t o;
    o.addr = output_addr;   o.off = output_offset;   o.hv = output_history_valid;
    o.ha = output_history_addr;   o.ml = output_meta_match_len;
    o.me = output_meta_match_can_ext;   o.data = output_data;
    o.last = output_last;   o.delim = output_delim;   o.empty = output_empty;
    return o;
  endfunction

  // A beat is consumed at the next rising edge when valid and ready hold mid-cycle
  always @(negedge clk) begin
    if (rst_n && output_valid && output_ready) begin
      obs_q.push_back(cur_beat());
      obs_cyc.push_back(cyc);
    end
  end

  function automatic void model_append(input batch_t b);
    beat_t e;
    int hi;
    logic [AW-1:0] a;
    if (b.rv == '0) begin
      if (b.delim) begin
        e = '0;
        e.addr = b.head;  e.last = 1'b1;  e.delim = 1'b1;  e.empty = 1'b1;
        exp_q.push_back(e);
      end
      return;
    end
    hi = 0;
    for (int i = 0; i < HW; i++) if (b.rv[i]) hi = i;
    for (int i = 0; i < HW; i++) begin
      if (b.rv[i]) begin
        e = '0;
        e.addr = b.head + AW'(i);
        e.off  = LW'(i);
        for (int j = 0; j < RS; j++) begin
          a = b.ha[(i*RS+j)*AW +: AW];
          e.ha[j*AW +: AW] = a;
          e.hv[j] = b.hv[i*RS+j] && (a < e.addr);
        end
        e.ml    = b.ml[i*RS*ML +: RS*ML];
        e.me    = b.me[i*RS +: RS];
        e.data  = b.data;
        e.last  = (i == hi);
        e.delim = (i == hi) && b.delim;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic batch_t rand_batch();
    batch_t b;
    b.head = AW'($urandom);
    b.rv   = HW'($urandom);
    if ($urandom_range(0, 7) == 0) b.rv = '0;
    b.hv   = (HW*RS)'($urandom);
    for (int s = 0; s < HW*RS; s++) b.ha[s*AW +: AW] = b.head + AW'($urandom_range(0, 8)) - AW'(4);
    b.ml    = (HW*RS*ML)'($urandom);
    b.me    = (HW*RS)'($urandom);
    b.data  = (HW*8)'($urandom);
    b.delim = 1'($urandom);
    return b;
  endfunction

  task automatic set_inputs(input batch_t b);
    input_head_addr = b.head;   input_row_valid = b.rv;
    input_history_valid_vec = b.hv;   input_history_addr_vec = b.ha;
    input_meta_match_len_vec = b.ml;   input_meta_match_can_ext_vec = b.me;
    input_data = b.data;   input_delim = b.delim;
  endtask

  task automatic clear_queues();
    obs_q.delete();  obs_cyc.delete();  exp_q.delete();
  endtask

  task automatic run_traffic(input int rdy_pct, input int max_cyc);
    int idx = 0;
    int idle = 0;
    int c = 0;
    int n = stim_q.size();
    while (c < max_cyc && !(idx >= n && idle >= 4)) begin
      @(posedge clk); #1;
      output_ready = ($urandom_range(0, 99) < rdy_pct);
      if (idx < n) begin
        set_inputs(stim_q[idx]);
        input_valid = 1'b1;
      end else begin
        input_valid = 1'b0;
      end
      @(negedge clk);
      if (input_valid && input_ready) begin
        model_append(stim_q[idx]);
        idx++;
      end
      idle = (idx >= n && !output_valid) ? idle + 1 : 0;
      c++;
    end
    input_valid = 1'b0;
    checks++;
    if (idx < n || idle < 4) begin
      errors++;
      $display("FAIL traffic_timeout: accepted %0d of %0d batches, idle %0d", idx, n, idle);
    end
    stim_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", input_ready); end
    checks++; if (output_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", output_last); end
    checks++; if (output_delim !== 1'b0) begin errors++; $display("FAIL reset_delim: got %b want 0", output_delim); end
    checks++; if (output_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", output_empty); end
    checks++; if (output_addr !== '0 || output_history_addr !== '0) begin
      errors++; $display("FAIL reset_data: got addr %h hist %h want 0", output_addr, output_history_addr);
    end
  endtask

  task automatic test_basic_1011();
    batch_t b = '0;
    b.head = 16'h0100;  b.rv = 4'b1011;  b.hv = '1;
    b.ha[(1*RS+0)*AW +: AW] = 16'h00F0;
    b.ha[(1*RS+1)*AW +: AW] = 16'h0101;
    @(posedge clk); #1;
    output_ready = 1'b1;
    set_inputs(b);
    input_valid = 1'b1;
    @(negedge clk);
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got ready %b want 1", input_ready); end
    @(posedge clk); #1 input_valid = 1'b0;
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got valid %b want 0", output_valid); end
    @(negedge clk);
    checks++; if ({output_valid, output_offset, output_addr, output_last} !== {1'b1, 2'd0, 16'h0100, 1'b0}) begin
      errors++; $display("FAIL basic_beat0: got v%b off %0d addr %h last %b", output_valid, output_offset, output_addr, output_last);
    end
    @(negedge clk);
    checks++; if ({output_valid, output_offset, output_addr, output_last} !== {1'b1, 2'd1, 16'h0101, 1'b0}) begin
      errors++; $display("FAIL basic_beat1: got v%b off %0d addr %h last %b", output_valid, output_offset, output_addr, output_last);
    end
    checks++; if (output_history_valid !== 2'b01) begin errors++; $display("FAIL basic_filter: got %b want 01", output_history_valid); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_last_load: got %b want 1", input_ready); end
    @(negedge clk);
    checks++; if ({output_valid, output_offset, output_addr, output_last, output_delim} !== {1'b1, 2'd3, 16'h0103, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_beat2: got v%b off %0d addr %h last %b delim %b", output_valid, output_offset, output_addr, output_last, output_delim);
    end
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got valid %b want 0", output_valid); end
  endtask

  task automatic test_backpressure();
    batch_t b;
    beat_t  snap;
    beat_t  o;
    b = rand_batch();
    b.rv = 4'b1111;
    clear_queues();
    model_append(b);
    @(posedge clk); #1;
    output_ready = 1'b1;
    set_inputs(b);
    input_valid = 1'b1;
    @(posedge clk); #1 input_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 output_ready = 1'b0;
    @(negedge clk);
    snap = cur_beat();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (!output_valid || cur_beat() !== snap) begin
        errors++; $display("FAIL stall_hold cycle %0d: got %h want %h", k, cur_beat(), snap);
      end
    end
    @(posedge clk); #1 output_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      o = obs_q[k];
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL stall_beat %0d: got %h want %h", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_delim_only();
    batch_t b = '0;
    b.head = 16'h02A0;  b.data = 32'hCAFE_F00D;  b.delim = 1'b1;
    @(posedge clk); #1;
    output_ready = 1'b1;
    set_inputs(b);
    input_valid = 1'b1;
    @(posedge clk); #1 input_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({output_valid, output_empty, output_last, output_delim} !== 4'b1111) begin
      errors++; $display("FAIL delim_flags: got v%b e%b l%b d%b want 1111", output_valid, output_empty, output_last, output_delim);
    end
    checks++; if ({output_history_valid, output_addr, output_offset} !== {2'b00, 16'h02A0, 2'd0}) begin
      errors++; $display("FAIL delim_fields: got hv %b addr %h off %0d", output_history_valid, output_addr, output_offset);
    end
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL delim_single: got valid %b want 0", output_valid); end
    b.delim = 1'b0;
    @(posedge clk); #1;
    set_inputs(b);
    input_valid = 1'b1;
    @(negedge clk);
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL drop_accept: got ready %b want 1", input_ready); end
    @(posedge clk); #1 input_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
        errors++; $display("FAIL drop_nobeat cycle %0d: got valid %b ready %b want 0 1", k, output_valid, input_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    batch_t b1, b2;
    b1 = rand_batch();  b1.rv = 4'b1111;  b1.delim = 1'b0;
    b2 = rand_batch();  b2.rv = 4'b0001;  b2.delim = 1'b1;
    clear_queues();
    stim_q.push_back(b1);
    stim_q.push_back(b2);
    run_traffic(100, 60);
    checks++;
    if (obs_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d beats want 5", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_cyc[k] != obs_cyc[0] + k) begin errors++; $display("FAIL b2b_gap beat %0d: got cycle %0d want %0d", k, obs_cyc[k], obs_cyc[0] + k); end
      checks++;
      if (obs_q[k].delim !== (k == 4)) begin errors++; $display("FAIL b2b_delim beat %0d: got %b", k, obs_q[k].delim); end
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    batch_t b;
    b = rand_batch();
    b.rv = 4'b1111;
    @(posedge clk); #1;
    output_ready = 1'b1;
    set_inputs(b);
    input_valid = 1'b1;
    @(posedge clk); #1 input_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_queues();
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", input_ready); end
    repeat (8) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_leak: got %0d beats want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    beat_t o;
    clear_queues();
    for (int k = 0; k < 40; k++) stim_q.push_back(rand_batch());
    run_traffic(60, 3000);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      o = obs_q[k];
      if (exp_q[k].empty) begin
        o.ha = exp_q[k].ha;  o.ml = exp_q[k].ml;  o.me = exp_q[k].me;  o.data = exp_q[k].data;
      end
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL rand_beat %0d: got %h want %h", k, o, exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_1011();
    test_backpressure();
    test_delim_only();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
